// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl shared types and constants.
// State encoding and default end-of-program instruction.
package boot_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  // jal x0,0 : tight self-loop used as the end marker
  localparam logic [31:0] HALT_INSN_DEF = 32'h0000_006f;

endpackage

// File: rtl/boot_ctrl_if.sv
// Loader handshake and instruction-memory write port.
// master = word source / memory side, slave = controller.
interface boot_ctrl_if #(
  parameter int AW = 6
);

  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );

endinterface

// File: rtl/boot_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/boot_ctrl.sv
// Boot controller: loads a program into instruction memory,
// releases the core, and stops it on end marker or timeout.
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] HALT_INSN  = HALT_INSN_DEF,
  parameter int          TIMEOUT    = 1000,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [AW:0] load_len,
  boot_ctrl_if.slave  bus,
  input  logic [31:0] core_insn,
  input  logic [31:0] core_pc,
  output logic        core_rst,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [31:0] halt_pc,
  output logic [31:0] cycle_cnt
);

  localparam logic [AW:0] DEPTH_W  = (AW+1)'(IMEM_DEPTH);
  localparam logic [AW:0] ONE_W    = (AW+1)'(1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] cnt;
  logic [AW:0]   len_q;
  logic          idle_like;
  logic          len_ok;
  logic          accept;
  logic          reject;
  logic          xfer;
  logic          last;
  logic          hit;
  logic          tmo;
  logic          stop;

  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_HALT);
    len_ok    = (load_len != '0) && (load_len <= DEPTH_W);
    accept    = idle_like && load_start && len_ok;
    reject    = idle_like && load_start && !len_ok;
    xfer      = (state == S_LOAD) && bus.in_valid;
    last      = xfer && ({1'b0, cnt} == (len_q - ONE_W));
    hit       = (state == S_RUN) && (core_insn == HALT_INSN);
    tmo       = (state == S_RUN) && (cycle_cnt == TMO_LAST);
    stop      = hit || tmo;
    nxt       = state;
    unique case (state)
      S_IDLE, S_HALT: if (accept) nxt = S_LOAD;
      S_LOAD:         if (last)   nxt = S_RUN;
      S_RUN:          if (stop)   nxt = S_HALT;
      default:        nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      len_q   <= '0;
      err     <= 1'b0;
      halt_pc <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        len_q <= load_len;
        err   <= 1'b0;
      end else if (xfer) begin
        cnt <= cnt + AW'(1);
      end
      // a timeout wins over a coincident end marker
      if (reject || tmo) err <= 1'b1;
      if (stop) halt_pc <= core_pc;
    end
  end

  sat_counter #(.W(32)) u_cyc (
    .clk (clk),
    .clr (rst || accept),
    .en  (state == S_RUN),
    .q   (cycle_cnt)
  );

  assign bus.in_ready   = (state == S_LOAD);
  assign bus.imem_we    = xfer;
  assign bus.imem_waddr = cnt;
  assign bus.imem_wdata = bus.in_data;
  assign core_rst       = (state != S_RUN);
  assign busy           = (state == S_LOAD) || (state == S_RUN);
  assign halted         = (state == S_HALT);

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl: write scoreboard,
// length-check table and run/halt/timeout/reset sequences.
module tb_boot_ctrl;
  import boot_ctrl_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [AW:0] load_len = '0;
  logic [31:0] core_insn = '0;
  logic [31:0] core_pc = '0;
  logic        core_rst;
  logic        busy;
  logic        halted;
  logic        err;
  logic [31:0] halt_pc;
  logic [31:0] cycle_cnt;

  boot_ctrl_if #(.AW(AW)) bus ();

  boot_ctrl #(
    .IMEM_DEPTH (DEPTH),
    .HALT_INSN  (HALT_INSN_DEF),
    .TIMEOUT    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .bus        (bus),
    .core_insn  (core_insn),
    .core_pc    (core_pc),
    .core_rst   (core_rst),
    .busy       (busy),
    .halted     (halted),
    .err        (err),
    .halt_pc    (halt_pc),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [AW:0] len;
    logic        err;
    logic        busy;
  } vec_t;

  wr_t  sb[$];
  vec_t tbl[5];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   wr_seen = 0;

  function automatic logic [31:0] word(input int i);
    if (i == 40) return 32'h0000_006f;
    return {8'hC0, 8'(i), 16'h0013};
  endfunction

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  // one clock: observe writes at negedge, return 1 after posedge
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (bus.imem_we) begin
      wr_seen++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_we: got write at %0d, required none",
                 bus.imem_waddr);
      end else begin
        e = sb.pop_front();
        chk("imem_write", 64'({bus.imem_waddr, bus.imem_wdata}), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int n, input bit stall, input int lim);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    wr_seen = 0;
    for (int i = 0; i < lim; i++) sb.push_back({AW'(i), word(i)});
    load_start = 1'b1;
    load_len = (AW+1)'(n);
    tick();
    load_start = 1'b0;
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_ready", 64'(bus.in_ready), 64'(1));
    chk("load_err", 64'(err), 64'(0));
    chk("load_halted", 64'(halted), 64'(0));
    chk("load_cyc_clr", 64'(cycle_cnt), 64'(0));
    while (k < lim && cyc < 400) begin
      bus.in_valid = stall ? cyc[0] : 1'b1;
      bus.in_data  = bus.in_valid ? word(k) : 32'hDEAD_BEEF;
      if (bus.in_valid) k++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk("load_bound", 64'(k), 64'(lim));
    chk("writes_seen", 64'(wr_seen), 64'(lim));
    chk("sb_drained", 64'(sb.size()), 64'(0));
    if (lim == n) begin
      chk("run_core_rst", 64'(core_rst), 64'(0));
      chk("run_ready", 64'(bus.in_ready), 64'(0));
      chk("run_busy", 64'(busy), 64'(1));
    end
  endtask

  task automatic run_halt(input logic [31:0] pc, input int pre);
    repeat (pre) tick();
    core_insn = HALT_INSN_DEF;
    core_pc   = pc;
    tick();
    core_insn = '0;
    chk("halt_halted", 64'(halted), 64'(1));
    chk("halt_core_rst", 64'(core_rst), 64'(1));
    chk("halt_busy", 64'(busy), 64'(0));
    chk("halt_pc", 64'(halt_pc), 64'(pc));
    chk("halt_err", 64'(err), 64'(0));
    chk("halt_cyc", 64'(cycle_cnt), 64'(pre + 1));
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_core_rst"}, 64'(core_rst), 64'(1));
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_halted"}, 64'(halted), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_cyc"}, 64'(cycle_cnt), 64'(0));
    chk({tag, "_halt_pc"}, 64'(halt_pc), 64'(0));
  endtask

  initial begin
    tbl[0] = '{len: 7'd0,   err: 1'b1, busy: 1'b0};
    tbl[1] = '{len: 7'd65,  err: 1'b1, busy: 1'b0};
    tbl[2] = '{len: 7'd127, err: 1'b1, busy: 1'b0};
    tbl[3] = '{len: 7'd4,   err: 1'b0, busy: 1'b1};
    tbl[4] = '{len: 7'd0,   err: 1'b0, busy: 1'b1};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_checks("reset");
    chk("reset_we", 64'(bus.imem_we), 64'(0));

    // length screening; last entry is ignored while loading
    for (int i = 0; i < 5; i++) begin
      load_start = 1'b1;
      load_len = tbl[i].len;
      tick();
      load_start = 1'b0;
      chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].err));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d_ready", i), 64'(bus.in_ready),
          64'(tbl[i].busy));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_checks("abort4");

    do_load(41, 1'b0, 41);
    bus.in_valid = 1'b1;
    run_halt(32'h0000_00A0, 2);
    bus.in_valid = 1'b0;

    do_load(41, 1'b1, 41);
    core_pc = 32'h0000_1234;
    repeat (7) tick();
    chk("pre_tmo_halted", 64'(halted), 64'(0));
    chk("pre_tmo_cyc", 64'(cycle_cnt), 64'(7));
    tick();
    chk("tmo_halted", 64'(halted), 64'(1));
    chk("tmo_err", 64'(err), 64'(1));
    chk("tmo_cyc", 64'(cycle_cnt), 64'(8));
    chk("tmo_pc", 64'(halt_pc), 64'h1234);
    chk("tmo_core_rst", 64'(core_rst), 64'(1));
    repeat (3) tick();
    chk("hold_halted", 64'(halted), 64'(1));
    chk("hold_cyc", 64'(cycle_cnt), 64'(8));

    do_load(1, 1'b0, 1);
    repeat (7) tick();
    core_insn = HALT_INSN_DEF;
    core_pc   = 32'h0000_0044;
    tick();
    core_insn = '0;
    chk("both_halted", 64'(halted), 64'(1));
    chk("both_err", 64'(err), 64'(1));
    chk("both_pc", 64'(halt_pc), 64'h44);

    do_load(41, 1'b0, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_checks("midrst");
    do_load(41, 1'b0, 41);
    run_halt(32'h0000_00B8, 0);

    do_load(64, 1'b0, 64);
    run_halt(32'h0000_0008, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameter IMEM_DEPTH, default 64: instruction-memory depth in 32-bit words; AW = clog2(IMEM_DEPTH).
REQ-002 Parameter HALT_INSN, default 32'h0000006f (jal x0,0): instruction word that marks program end.
REQ-003 Parameter TIMEOUT, default 1000: maximum RUN cycles before a forced halt.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 load_start  in  1  request a program load; sampled in IDLE/HALT only.
REQ-007 load_len  in  AW+1  number of words to load; valid with load_start.
REQ-008 in_valid  in  1  loader word valid.
REQ-009 in_data  in  32  loader instruction word.
REQ-010 in_ready  out  1  controller accepts a word this cycle.
REQ-011 imem_we  out  1  instruction-memory write enable.
REQ-012 imem_waddr  out  AW  instruction-memory word address.
REQ-013 imem_wdata  out  32  instruction-memory write data.
REQ-014 core_insn  in  32  instruction currently fetched by the datapath.
REQ-015 core_pc  in  32  current datapath PC.
REQ-016 core_rst  out  1  reset driven to the datapath, active-high.
REQ-017 busy  out  1  load or run in progress.
REQ-018 halted  out  1  program finished or forced stop.
REQ-019 err  out  1  bad load_len or timeout.
REQ-020 halt_pc  out  32  core_pc captured at halt.
REQ-021 cycle_cnt  out  32  RUN cycles executed, saturating.

Function
REQ-022 FSM states IDLE, LOAD, RUN, HALT; one registered state.
REQ-023 IDLE/HALT + load_start + 1<=load_len<=IMEM_DEPTH -> LOAD next cycle; word counter=0, cycle_cnt=0, halted=0, err=0, busy=1.
REQ-024 IDLE/HALT + load_start + (load_len==0 or >IMEM_DEPTH) -> remain in state, err=1 next cycle, held until the next accepted load_start.
REQ-025 load_start in LOAD or RUN ignored.
REQ-026 in_ready=1 iff state==LOAD; transfer = in_valid && in_ready.
REQ-027 On transfer (same cycle, combinational): imem_we=1, imem_waddr=counter, imem_wdata=in_data; counter increments on the edge.
REQ-028 imem_we=0 in every cycle without a transfer; in_valid stalls add cycles, never drop or duplicate words.
REQ-029 Transfer with counter==load_len-1 -> RUN next cycle; no further words accepted.
REQ-030 core_rst=1 in IDLE, LOAD, HALT; core_rst=0 in RUN.
REQ-031 RUN: cycle_cnt increments each cycle, saturates at 32'hFFFFFFFF.
REQ-032 RUN + core_insn==HALT_INSN -> HALT next cycle; halt_pc<=core_pc; err unchanged.
REQ-033 RUN + cycle_cnt==TIMEOUT-1 with no HALT_INSN -> HALT next cycle, err=1, halt_pc<=core_pc.
REQ-034 HALT_INSN and timeout same cycle: HALT with err=1.
REQ-035 HALT: halted=1, busy=0, core_rst=1; state held until load_start.

Reset
REQ-036 rst (any state, incl. mid-LOAD/RUN) -> IDLE next edge; core_rst=1, in_ready=0, imem_we=0, busy=0, halted=0, err=0, counter=0, cycle_cnt=0, halt_pc=0.
REQ-037 Instruction-memory contents are not cleared by rst; partially loaded words remain.

Structure
REQ-038 Package boot_ctrl_pkg holds the state enum and the default HALT_INSN constant.
REQ-039 One sub-module sat_counter (32-bit, clear/enable, saturating) implements cycle_cnt.

Verification
REQ-040 Load 41 words (index 40 = 32'h0000006f), in_valid continuous -> 41 imem_we pulses, addr 0..40, RUN on cycle after last word.
REQ-041 Same load with in_valid low every other cycle -> identical address/data sequence, 41 writes, no duplicates.
REQ-042 load_len=0, then load_len=65 -> err=1, state IDLE, no imem_we; then load_len=4 -> err=0, LOAD entered.
REQ-043 core_insn=32'h0000006f at core_pc=32'hA0 in RUN -> halted=1, core_rst=1, halt_pc=32'hA0, err=0.
REQ-044 TIMEOUT=8, core_insn never HALT_INSN -> HALT after 8 RUN cycles, err=1, cycle_cnt=8.
REQ-045 rst after 10 of 41 words -> IDLE, in_ready=0, core_rst=1; new load from word 0 completes normally.
